// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding the instruction-memory load path.
// Ports: clk/reset, start, in_* descriptor handshake, imem_* write, busy/done/err/count status.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_cls,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [2:0] C_R    = 3'd0;
  localparam logic [2:0] C_I    = 3'd1;
  localparam logic [2:0] C_B    = 3'd2;
  localparam logic [2:0] C_LD   = 3'd3;
  localparam logic [2:0] C_S    = 3'd4;
  localparam logic [2:0] C_JAL  = 3'd5;
  localparam logic [2:0] C_LUI  = 3'd6;

  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   C_ONE  = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         enc;
  logic [6:0]          i_hi;
  logic                bad;

  // Shift-immediate forms take bit 30 from f7b5, not from the immediate.
  always_comb begin
    i_hi = in_imm[11:5];
    if (in_funct3 == 3'b001) i_hi = 7'b0;
    if (in_funct3 == 3'b101) i_hi = {1'b0, in_f7b5, 5'b0};
  end

  always_comb begin
    enc = '0;
    unique case (in_cls)
      C_R:   enc = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1,
                    in_funct3, in_rd, 7'b0110011};
      C_I:   enc = {i_hi, in_imm[4:0], in_rs1,
                    in_funct3, in_rd, 7'b0010011};
      C_LD:  enc = {in_imm[11:0], in_rs1,
                    in_funct3, in_rd, 7'b0000011};
      C_S:   enc = {in_imm[11:5], in_rs2, in_rs1,
                    in_funct3, in_imm[4:0], 7'b0100011};
      C_B:   enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                    in_funct3, in_imm[4:1], in_imm[11], 7'b1100011};
      C_JAL: enc = {in_imm[20], in_imm[10:1], in_imm[11],
                    in_imm[19:12], in_rd, 7'b1101111};
      C_LUI: enc = {in_imm[31:12], in_rd, 7'b0110111};
      default: enc = '0;
    endcase
  end

  assign bad = (in_cls == 3'd7) |
               (((in_cls == C_B) | (in_cls == C_JAL)) & in_imm[0]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = A_BASE;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (bad) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = enc;
            count_d = count_q + C_ONE;
            // Hold at the top address; the session ends there.
            if (addr_q != A_MAX) addr_d = addr_q + 1'b1;
          end
          if (in_last | (~bad & (addr_q == A_MAX)))
            state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign count      = count_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised bench for instr_encoder against an arithmetic reference model.
// Two instances: default width, and ADDR_W=2 for the address-limit case.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [2:0]  in_cls = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_f7b5 = 1'b0;
  logic [31:0] in_imm = '0;
  logic        in_ready, imem_we, busy, done, err;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;

  logic        s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [1:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .reset(reset), .start(s_start),
    .in_valid(s_valid), .in_ready(s_ready), .in_last(s_last),
    .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
    .imem_we(s_we), .imem_waddr(s_waddr), .imem_wdata(s_wdata),
    .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cnt;
  } wr_t;

  wr_t exp_q[$];
  int  s_obs[$];
  int  n_chk = 0, n_err = 0;
  int  m_st = 0, m_addr = 0, m_cnt = 0;
  bit  m_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(input int cls, input int rd,
      input int rs1, input int rs2, input int f3, input bit f7,
      input logic [31:0] im);
    logic [31:0] regs, i12;
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    case (cls)
      0: return (32'(f7) << 30) | (32'(rs2) << 20) | regs
                | (32'(rd) << 7) | 32'h33;
      1: begin
        i12 = im & 32'hFFF;
        if (f3 == 1) i12 = im & 32'h1F;
        if (f3 == 5) i12 = (im & 32'h1F) | (f7 ? 32'h400 : 32'h0);
        return (i12 << 20) | regs | (32'(rd) << 7) | 32'h13;
      end
      3: return ((im & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'h03;
      4: return (((im >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
                | ((im & 32'h1F) << 7) | 32'h23;
      2: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25)
                | (32'(rs2) << 20) | regs | (((im >> 1) & 32'hF) << 8)
                | (((im >> 11) & 1) << 7) | 32'h63;
      5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12)
                | (32'(rd) << 7) | 32'h6F;
      6: return (im & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", {24'h0, imem_waddr}, 32'hFFFFFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", 32'(imem_waddr), e.addr);
        check("wdata", imem_wdata, e.data);
        check("wcount", 32'(count), e.cnt);
      end
    end
    if (s_we === 1'b1) s_obs.push_back(int'(s_waddr));
  end

  task automatic check_status();
    check("busy", 32'(busy), 32'(m_st == 1));
    check("done", 32'(done), 32'(m_st == 2));
    check("ready", 32'(in_ready), 32'(m_st == 1));
    check("err", 32'(err), 32'(m_err));
    check("count", 32'(count), m_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    m_st = 0; m_addr = 0; m_cnt = 0; m_err = 0;
    #1 reset = 1'b0;
    check_status();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    if (m_st != 1) begin
      m_st = 1; m_addr = 0; m_cnt = 0; m_err = 0;
    end
    #1 start = 1'b0;
    check_status();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_status();
  endtask

  task automatic send(input int cls, input int rd, input int rs1,
      input int rs2, input int f3, input bit f7, input logic [31:0] im,
      input bit last, input logic [32:0] fx);
    bit bad, hit;
    in_valid = 1'b1; in_last = last;
    in_cls = 3'(cls); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_f7b5 = f7; in_imm = im;
    check("ready_pre", 32'(in_ready), 32'(m_st == 1));
    @(posedge clk);
    if (m_st == 1) begin
      bad = (cls == 7) || ((cls == 2 || cls == 5) && im[0]);
      hit = !bad && (m_addr == 255);
      if (bad) begin
        m_err = 1;
      end else begin
        m_cnt++;
        exp_q.push_back('{m_addr,
          fx[32] ? fx[31:0] : ref_enc(cls, rd, rs1, rs2, f3, f7, im),
          m_cnt});
        if (!hit) m_addr++;
      end
      if (last || hit) m_st = 2;
    end
    #1 in_valid = 1'b0; in_last = 1'b0;
    check_status();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_we", 32'(imem_we), 0);
    check("rst_waddr", 32'(imem_waddr), 0);
    check("rst_wdata", imem_wdata, 0);
    check_status();

    do_start();
    send(1, 1, 0, 0, 0, 0, 32'd5, 0, {1'b1, 32'h00500093});
    idle();

    do_reset();
    do_start();
    send(0, 3, 1, 2, 0, 1, 32'd0, 0, {1'b1, 32'h402081B3});
    send(4, 0, 1, 2, 2, 0, 32'd8, 0, {1'b1, 32'h0020A423});
    send(2, 0, 0, 0, 0, 0, -32'sd4, 0, {1'b1, 32'hFE000EE3});
    send(5, 1, 0, 0, 0, 0, 32'd8, 0, {1'b1, 32'h008000EF});
    send(6, 5, 0, 0, 0, 0, 32'h12345000, 1, {1'b1, 32'h123452B7});
    idle();
    check("stream_done", 32'(done), 1);
    check("stream_cnt", 32'(count), 5);

    do_start();
    send(7, 1, 2, 3, 0, 0, 32'd0, 0, 33'h0);
    send(2, 0, 1, 2, 0, 0, 32'd3, 0, 33'h0);
    check("rej_err", 32'(err), 1);
    check("rej_cnt", 32'(count), 0);
    send(1, 2, 0, 0, 0, 0, 32'd7, 1, {1'b1, 32'h00700113});
    idle();

    do_start();
    check("restart_err", 32'(err), 0);
    check("restart_cnt", 32'(count), 0);
    check("restart_busy", 32'(busy), 1);
    send(6, 7, 0, 0, 0, 0, 32'hABCDE000, 0, {1'b1, 32'hABCDE3B7});
    idle();

    in_valid = 1'b1; in_cls = 3'd1; in_imm = 32'd9; reset = 1'b1;
    @(posedge clk);
    m_st = 0; m_addr = 0; m_cnt = 0; m_err = 0;
    #1 reset = 1'b0; in_valid = 1'b0;
    check("rst_acc_we", 32'(imem_we), 0);
    check_status();
    idle();
    do_start();
    send(1, 4, 4, 0, 0, 0, 32'd1, 1, {1'b1, 32'h00120213});
    idle();

    in_cls = 3'd1; in_rd = 5'd1; in_rs1 = 5'd0;
    in_funct3 = 3'd0; in_imm = 32'd1;
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    s_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (s_ready) acc++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("small_acc", acc, 4);
    check("small_nwr", s_obs.size(), 4);
    for (int i = 0; i < s_obs.size(); i++) check("small_addr", s_obs[i], i);
    check("small_done", 32'(s_done), 1);
    check("small_cnt", 32'(s_count), 4);
    check("small_ready", 32'(s_ready), 0);

    for (int s = 0; s < 25; s++) begin
      int len;
      do_start();
      len = $urandom_range(1, 30);
      for (int i = 0; i < len && m_st == 1; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        if ($urandom_range(0, 9) == 0) do_start();
        if ($urandom_range(0, 60) == 0) begin
          do_reset();
          break;
        end
        send($urandom_range(0, 7), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), 1'($urandom), $urandom,
             (i == len - 1) || ($urandom_range(0, 9) == 0), 33'h0);
      end
      idle();
    end

    repeat (3) @(posedge clk);
    #1 check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and instruction-memory loader: the inverse of the main decoder. It accepts instruction descriptions (class plus register/funct/immediate fields) over a valid/ready handshake, assembles the 32-bit machine word, and writes it into instruction memory at consecutive word addresses. It sits on the boot/test-load path in front of the instruction memory and covers exactly the opcode classes the main decoder supports: R, I-ALU, branch, load, store, jal and lui.

## Interface

Parameters:
- ADDR_W, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0: first word address written after `start`.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: begin a load session; sampled only in IDLE or DONE.
- in_valid, in, 1: instruction descriptor valid.
- in_ready, out, 1: encoder can accept a descriptor this cycle.
- in_last, in, 1: the descriptor is the final one of the session.
- in_cls, in, 3: 0=R, 1=I-ALU, 2=B, 3=LOAD, 4=S, 5=JAL, 6=LUI, 7=invalid.
- in_rd, in_rs1, in_rs2, in, 5 each: register fields.
- in_funct3, in, 3: funct3 field.
- in_f7b5, in, 1: instruction bit 30 (sub/sra/srai select).
- in_imm, in, 32: immediate, as a signed byte offset or raw value.
- imem_we, out, 1: instruction-memory write strobe.
- imem_waddr, out, ADDR_W: word address.
- imem_wdata, out, 32: encoded instruction.
- busy, out, 1: state is LOAD.
- done, out, 1: state is DONE.
- err, out, 1: sticky flag; a descriptor was rejected.
- count, out, ADDR_W+1: number of words written this session.

## Operation

- States:
  - IDLE: in_ready=0. `start` moves to LOAD, loads the address counter with BASE_ADDR, and clears count and err.
  - LOAD: in_ready=1. Each accepted descriptor (in_valid & in_ready) is encoded and registered.
  - DONE: in_ready=0. `start` restarts the session exactly as from IDLE.
- Transition LOAD→DONE takes place on acceptance of a descriptor with in_last=1, or on acceptance of the descriptor that targets address 2^ADDR_W−1. That descriptor is still written. The address never wraps.
- Encoding (opcode in bits [6:0]):
  - R: {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, 0110011}.
  - I-ALU: {imm[11:0], rs1, funct3, rd, 0010011}.
    - funct3=001 forces bits[31:25]=0.
    - funct3=101 forces bits[31:25]={1'b0, f7b5, 5'b0}.
  - LOAD: {imm[11:0], rs1, funct3, rd, 0000011}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
  - LUI: {imm[31:12], rd, 0110111}.
- Upper immediate bits that do not fit the format are dropped silently. No range check is performed.
- Rejection: a descriptor is rejected if in_cls=7, or if it is class B or JAL with imm[0]=1.
  - The descriptor is still consumed (handshake completes).
  - No write occurs, the address and count are unchanged, and err is set.
  - in_last on a rejected descriptor still moves the state to DONE.
- The address counter and count increment by 1 per write.

## Timing

- Reset values: state IDLE, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, err=0, count=0.
- Latency: a descriptor accepted on edge N produces imem_we=1 with the registered waddr/wdata during cycle N+1, for exactly one cycle.
- Throughput: one descriptor per cycle in LOAD.
- in_ready is a function of state only. It drops in the cycle after acceptance of the terminating descriptor, so back-to-back valid is safe.
- count and busy/done update on the same edge as the write registers.
- `start` while in LOAD is ignored.
- Reset has priority over all other inputs. Reset mid-session returns to IDLE and cancels any pending write: imem_we=0 in the cycle after reset.

## Test plan

- reset, then start, then I-ALU addi x1,x0,5 (rd=1, rs1=0, funct3=0, imm=5) → cycle after acceptance: imem_we=1, waddr=0, wdata=0x00500093, count=1.
- Back-to-back stream with BASE_ADDR=0:
  - R sub x3,x1,x2 (f7b5=1) → 0x402081B3 @0.
  - S sw x2,8(x1) (funct3=010) → 0x0020A423 @1.
  - B beq x0,x0,−4 → 0xFE000EE3 @2.
  - JAL x1,+8 → 0x008000EF @3.
  - LUI x5,0x12345000 with in_last=1 → 0x123452B7 @4.
  - After the last write: done=1, count=5, in_ready=0.
- in_cls=7, then B with imm=3 → no imem_we, err=1, count unchanged. A following valid descriptor is written at the unadvanced address.
- ADDR_W=2: send 6 descriptors without in_last → writes at addresses 0..3 only, done=1 after the 4th, in_ready=0 so descriptors 5 and 6 are never accepted.
- Assert reset in the same cycle as an accepted descriptor → no write follows, state IDLE, count=0. A new start then writes from BASE_ADDR.
- In DONE, assert start → count=0, err=0, busy=1, and the next write goes to BASE_ADDR.
